// File: rtl/nibble_add_if.sv
// nibble_add_if
//   Start/ready/done bundle between the calculator control and the serial
//   nibble adder.
//
//   Handshake: the master raises start together with the operands. The
//   request is taken on a rising clock edge where start=1 and ready=1; a and
//   b (and sub, when the subtract option NIBBLE_ADD_SUB_EN is compiled in)
//   are sampled on that same edge. start while ready=0 is dropped, not
//   queued. Completion is a one-cycle done pulse; sum and c_out are valid
//   from that cycle and hold until the next accepted start.
//
//   Signals:
//     start  master->slave  request
//     a, b   master->slave  operands, W = 4*NIBBLES bits
//     sub    master->slave  subtract select (NIBBLE_ADD_SUB_EN only)
//     ready  slave->master  idle, can accept a request
//     busy   slave->master  nibble loop in progress
//     done   slave->master  result valid pulse
//     sum    slave->master  result register
//     c_out  slave->master  carry out of the top nibble
interface nibble_add_if #(
    parameter int NIBBLES = 2
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
`ifdef NIBBLE_ADD_SUB_EN
    logic         sub;
`endif
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         c_out;

    modport master (
`ifdef NIBBLE_ADD_SUB_EN
        output sub,
`endif
        output start, a, b,
        input  ready, busy, done, sum, c_out
    );

    modport slave (
`ifdef NIBBLE_ADD_SUB_EN
        input  sub,
`endif
        input  start, a, b,
        output ready, busy, done, sum, c_out
    );
endinterface

// File: rtl/nibble_add_sequencer.sv
// nibble_add_sequencer
//   Multi-cycle unsigned adder: one 4-bit carry-lookahead slice is reused
//   once per clock, low nibble first, to add two W = 4*NIBBLES bit operands.
//   The inter-nibble carry is kept in a register and each nibble result is
//   written into the sum register as it is produced.
//
//   Optional feature macro: NIBBLE_ADD_SUB_EN adds a sub input on the bus.
//   With sub=1 the B operand is stored inverted and the carry starts at 1,
//   giving (a-b) mod 2^W; c_out=1 then means no borrow.
//
//   Ports:
//     clk        system clock, rising edge
//     rst        synchronous active-high reset, overrides everything
//     bus        nibble_add_if slave (start/a/b[/sub] in, ready/busy/done/
//                sum/c_out out)
//     state_dbg  current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
//   Timing: request taken at edge A, RUN for NIBBLES cycles, done high for
//   the single DONE cycle, back in IDLE one edge later. Issue interval is
//   NIBBLES+2 cycles.

module nibble_add_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] s,
    output logic       c_out
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g = a & b;
        p = a ^ b;
        // Every carry is expanded from c_in directly instead of rippling.
        c[0] = c_in;
        c[1] = g[0] | (p[0] & c_in);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c_in);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c_in);
        s     = p ^ c[3:0];
        c_out = c[4];
    end
endmodule

module nibble_add_sequencer #(
    parameter int NIBBLES = 2
) (
    input  logic         clk,
    input  logic         rst,
    nibble_add_if.slave  bus,
    output logic [1:0]   state_dbg
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES < 2) ? 1 : $clog2(NIBBLES + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic          carry;
    logic          ready_q;
    logic          busy_q;
    logic          done_q;
    logic [W-1:0]  sum_q;
    logic          c_out_q;

    logic [3:0]    a_nib;
    logic [3:0]    b_nib;
    logic [3:0]    s_nib;
    logic          c_nib;

    // Operand values as captured; subtraction folds into add as a + ~b + 1.
    logic [W-1:0]  b_load;
    logic          carry_load;

`ifdef NIBBLE_ADD_SUB_EN
    always_comb begin
        b_load     = bus.sub ? ~bus.b : bus.b;
        carry_load = bus.sub;
    end
`else
    always_comb begin
        b_load     = bus.b;
        carry_load = 1'b0;
    end
`endif

    always_comb begin
        a_nib = a_reg[4*int'(idx) +: 4];
        b_nib = b_reg[4*int'(idx) +: 4];
    end

    nibble_add_cla4 u_cla (
        .a     (a_nib),
        .b     (b_nib),
        .c_in  (carry),
        .s     (s_nib),
        .c_out (c_nib)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            carry   <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_reg   <= bus.a;
                        b_reg   <= b_load;
                        carry   <= carry_load;
                        idx     <= '0;
                        sum_q   <= '0;
                        state   <= RUN;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    sum_q[4*int'(idx) +: 4] <= s_nib;
                    carry <= c_nib;
                    if (idx == LAST_IDX) begin
                        // Index stays at the last nibble; it is reloaded on
                        // the next accepted start.
                        c_out_q <= c_nib;
                        state   <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    // Unused encoding: quiet return to IDLE.
                    state   <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;
    assign state_dbg = state;
endmodule

// File: tb/tb_nibble_add_sequencer.sv
// tb_nibble_add_sequencer
//   Drives a 2-nibble and a 4-nibble instance and compares every result
//   against an arithmetic reference model through an expected-value queue.
//   Inputs change 1 time unit after a rising edge; outputs are read at the
//   same point, so each value seen is the one left by the preceding edge.
module tb_nibble_add_sequencer;
    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nibble_add_if #(.NIBBLES(2)) if2 ();
    nibble_add_if #(.NIBBLES(4)) if4 ();
    logic [1:0] st2;
    logic [1:0] st4;

    nibble_add_sequencer #(.NIBBLES(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .bus       (if2.slave),
        .state_dbg (st2)
    );

    nibble_add_sequencer #(.NIBBLES(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .bus       (if4.slave),
        .state_dbg (st4)
    );

    // scoreboard: {c_out, sum} packed into 33 bits
    localparam int EW = 33;
    logic [EW-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the full-width values.
    function automatic logic [EW-1:0] model(input logic [31:0] av, input logic [31:0] bv,
                                            input logic sv, input int w);
        longint unsigned m;
        longint unsigned x;
        longint unsigned y;
        longint unsigned r;
        logic            c;
        m = 64'd1 << w;
        x = longint'(av) % m;
        y = longint'(bv) % m;
        if (sv) begin
            r = (x + m - y) % m;
            c = (x >= y);
        end else begin
            r = (x + y) % m;
            c = ((x + y) >= m);
        end
        return {c, r[31:0]};
    endfunction

    function automatic logic done_of(input int n);
        return (n == 2) ? if2.done : if4.done;
    endfunction
    function automatic logic busy_of(input int n);
        return (n == 2) ? if2.busy : if4.busy;
    endfunction
    function automatic logic ready_of(input int n);
        return (n == 2) ? if2.ready : if4.ready;
    endfunction
    function automatic logic [EW-1:0] result_of(input int n);
        return (n == 2) ? {if2.c_out, 24'd0, if2.sum} : {if4.c_out, 16'd0, if4.sum};
    endfunction

    // driver tasks
    task automatic drive(input int n, input logic st, input logic [31:0] av, input logic [31:0] bv);
        if (n == 2) begin
            if2.start = st;
            if2.a     = av[7:0];
            if2.b     = bv[7:0];
        end else begin
            if4.start = st;
            if4.a     = av[15:0];
            if4.b     = bv[15:0];
        end
    endtask

    task automatic drive_sub(input int n, input logic sv);
`ifdef NIBBLE_ADD_SUB_EN
        if (n == 2) if2.sub = sv;
        else        if4.sub = sv;
`else
        if (sv) $display("FAIL sub_unsupported: got 0x1 expected 0x0");
`endif
    endtask

    // One request of one cycle; timing checks optional (tm=1).
    task automatic run_op(input string tag, input int n, input logic [31:0] av,
                          input logic [31:0] bv, input logic sv, input bit tm);
        int  lat;
        int  busy_n;
        bit  seen;
        exp_q.push_back(model(av, bv, sv, 4 * n));
        @(posedge clk); #1;                       // start edge S
        drive_sub(n, sv);
        drive(n, 1'b1, av, bv);
        lat = 0; busy_n = 0; seen = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                drive(n, 1'b0, av, bv);
                if (tm) check({tag, "_ready_drop"}, 64'(ready_of(n)), 64'd0);
            end
            if (busy_of(n)) busy_n++;
            if (done_of(n)) begin
                seen = 1;
                lat  = k;
            end
        end
        if (!seen) begin
            check({tag, "_done_timeout"}, 64'd0, 64'd1);
            void'(exp_q.pop_front());
        end else begin
            check({tag, "_result"}, 64'(result_of(n)), 64'(exp_q.pop_front()));
            if (tm) begin
                // done seen after edge S+n+1, i.e. sampled high at edge S+n+2
                check({tag, "_latency"}, 64'(lat), 64'(n + 1));
                check({tag, "_busy_cycles"}, 64'(busy_n), 64'(n));
            end
            @(posedge clk); #1;
            check({tag, "_done_pulse"}, 64'(done_of(n)), 64'd0);
            if (tm) check({tag, "_ready_back"}, 64'(ready_of(n)), 64'd1);
        end
        drive_sub(n, 1'b0);
    endtask

    task automatic wait_done2(input string tag);
        bit seen;
        seen = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk); #1;
            if (if2.done) seen = 1;
        end
        if (!seen) check({tag, "_done_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        int done_cnt;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;

        drive(2, 1'b0, 32'd0, 32'd0);
        drive(4, 1'b0, 32'd0, 32'd0);
`ifdef NIBBLE_ADD_SUB_EN
        if2.sub = 1'b0;
        if4.sub = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset values
        check("rst_ready2", 64'(if2.ready), 64'd1);
        check("rst_busy2",  64'(if2.busy),  64'd0);
        check("rst_done2",  64'(if2.done),  64'd0);
        check("rst_sum2",   64'(if2.sum),   64'd0);
        check("rst_cout2",  64'(if2.c_out), 64'd0);
        check("rst_state2", 64'(st2),       64'd0);
        check("rst_ready4", 64'(if4.ready), 64'd1);
        check("rst_sum4",   64'(if4.sum),   64'd0);
        check("rst_cout4",  64'(if4.c_out), 64'd0);

        // directed adds
        run_op("add_3a_45", 2, 32'h3A, 32'h45, 1'b0, 1'b1);
        run_op("add_0f_01", 2, 32'h0F, 32'h01, 1'b0, 1'b0);
        run_op("add_ff_01", 2, 32'hFF, 32'h01, 1'b0, 1'b0);
        // result holds in IDLE after done
        repeat (2) @(posedge clk);
        #1 check("hold_after_done", 64'({if2.c_out, if2.sum}), 64'h100);

        // start held high through RUN and DONE with changing operands
        @(posedge clk); #1;
        drive(2, 1'b1, 32'h12, 32'h34);
        @(posedge clk); #1;
        drive(2, 1'b1, 32'hAA, 32'hAA);
        wait_done2("ign1");
        check("ign1_result", 64'({if2.c_out, if2.sum}), 64'h046);
        @(posedge clk); #1;                       // back in IDLE, start still high
        check("ign_idle_hold", 64'({if2.c_out, if2.sum}), 64'h046);
        @(posedge clk); #1;                       // second request taken
        drive(2, 1'b0, 32'h0, 32'h0);
        check("ign2_busy", 64'(if2.busy), 64'd1);
        wait_done2("ign2");
        check("ign2_result", 64'({if2.c_out, if2.sum}), 64'h154);
        repeat (2) @(posedge clk);

        // reset during first RUN cycle
        #1 drive(2, 1'b1, 32'h77, 32'h11);
        @(posedge clk); #1;
        drive(2, 1'b0, 32'h0, 32'h0);
        check("mid_state_run", 64'(st2), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_ready", 64'(if2.ready), 64'd1);
        check("mid_busy",  64'(if2.busy),  64'd0);
        check("mid_sum",   64'(if2.sum),   64'd0);
        check("mid_cout",  64'(if2.c_out), 64'd0);
        done_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (if2.done) done_cnt++;
        end
        check("mid_no_done", 64'(done_cnt), 64'd0);
        run_op("after_rst", 2, 32'h01, 32'h02, 1'b0, 1'b0);

        // 4-nibble boundary and random sweep
        run_op("add4_ffff_0001", 4, 32'hFFFF, 32'h0001, 1'b0, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            ra = 32'($urandom_range(0, 16'hFFFF));
            rb = 32'($urandom_range(0, 16'hFFFF));
            run_op("rand4", 4, ra, rb, 1'b0, 1'b0);
        end
        for (int i = 0; i < 100; i++) begin
            ra = 32'($urandom_range(0, 8'hFF));
            rb = 32'($urandom_range(0, 8'hFF));
            run_op("rand2", 2, ra, rb, 1'b0, 1'b0);
        end

`ifdef NIBBLE_ADD_SUB_EN
        run_op("sub_05_07", 2, 32'h05, 32'h07, 1'b1, 1'b1);
        run_op("sub_07_05", 2, 32'h07, 32'h05, 1'b1, 1'b0);
        for (int i = 0; i < 200; i++) begin
            ra = 32'($urandom_range(0, 16'hFFFF));
            rb = 32'($urandom_range(0, 16'hFFFF));
            rs = 1'($urandom_range(0, 1));
            run_op("rand_addsub4", 4, ra, rb, rs, 1'b0);
        end
`endif

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
